extbus_master: RTL and testbench

Synthesizable, parametrised 65C02-style external-bus cycle generator. It turns a valid/ready command stream (read/write, address, data, repeat count) into phi2-timed bus cycles with chip-select decode, read/write strobes and read-data capture. It is used as an on-chip stimulus/loopback master in front of the VERA host-bus port, and as a reusable bus-functional master in self-checking benches.

---
 rtl/extbus_defs.sv | 26 ++
 rtl/extbus_phi2_gen.sv | 48 ++++
 rtl/extbus_master.sv | 133 +++++++++++++
 tb/tb_extbus_master.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/extbus_defs.sv
// Shared constants for the extbus cycle generator: idle bus address, phase compare points
// and the legality check applied to the timing parameters at elaboration.
package extbus_defs;

    localparam logic [63:0] IDLE_ADDR = 64'h0;

    // Strobes fire in the cycle *before* the named phase, so the registered
    // update becomes visible exactly when the phase counter reaches it.
    function automatic int phase_last(input int half);
        return 2 * half - 1;
    endfunction

    function automatic int phase_addr(input int addr_dly);
        return addr_dly - 1;
    endfunction

    function automatic int phase_data(input int half, input int data_dly);
        return half + data_dly - 1;
    endfunction

    function automatic bit params_ok(input int half, input int addr_dly, input int data_dly);
        return (half >= 2) && (addr_dly >= 1) && (addr_dly < half) &&
               (data_dly >= 0) && (data_dly < half);
    endfunction

endpackage

// File: rtl/extbus_phi2_gen.sv
// phi2 phase counter (period 2*HALF clk) with registered phi2 and one-cycle timing strobes.
// Free-running, no backpressure; strobes are asserted the cycle before the edge they name.
module extbus_phi2_gen
    import extbus_defs::*;
#(
    parameter int HALF     = 3,
    parameter int ADDR_DLY = 1,
    parameter int DATA_DLY = 1
) (
    input  logic clk,
    input  logic rst,
    output logic phi2,
    output logic at_fall,
    output logic at_addr,
    output logic at_data,
    output logic at_sample
);

    localparam int              PH_W    = $clog2(2 * HALF);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(phase_last(HALF));
    localparam logic [PH_W-1:0] PH_ADDR = PH_W'(phase_addr(ADDR_DLY));
    localparam logic [PH_W-1:0] PH_DATA = PH_W'(phase_data(HALF, DATA_DLY));
    localparam logic [PH_W-1:0] PH_HIGH = PH_W'(HALF);

    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_nxt;

    always_comb begin
        phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    end

    // phi2 is registered from the next phase so it always equals (phase >= HALF).
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            phi2  <= 1'b0;
        end else begin
            phase <= phase_nxt;
            phi2  <= (phase_nxt >= PH_HIGH);
        end
    end

    assign at_fall   = (phase == PH_LAST);
    assign at_sample = (phase == PH_LAST);
    assign at_addr   = (phase == PH_ADDR);
    assign at_data   = (phase == PH_DATA);

endmodule

// File: rtl/extbus_master.sv
// 65C02-style bus master: one command (count beats) -> phi2-timed cycles, one beat per 2*HALF clk.
// cmd_ready = !busy (single command register); rsp is a 1-cycle pulse with no backpressure.
module extbus_master
    import extbus_defs::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                COUNT_W   = 8,
    parameter int                HALF      = 3,
    parameter int                ADDR_DLY  = 1,
    parameter int                DATA_DLY  = 1,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(16'h9F20),
    parameter logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(16'hFFF0)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [7:0]         cmd_data,
    input  logic [COUNT_W-1:0] cmd_count,
    output logic               rsp_valid,
    output logic [7:0]         rsp_data,
    output logic               busy,
    output logic               extbus_phi2,
    output logic [ADDR_W-1:0]  extbus_a,
    output logic               extbus_rw_n,
    output logic               extbus_cs_n,
    output logic               extbus_rd_n,
    output logic               extbus_wr_n,
    output logic [7:0]         extbus_d_out,
    output logic               extbus_d_oe,
    input  logic [7:0]         extbus_d_in
);

    if (!params_ok(HALF, ADDR_DLY, DATA_DLY)) begin : g_param_err
        $error("extbus_master: need HALF>=2, 1<=ADDR_DLY<HALF, 0<=DATA_DLY<HALF");
    end

    localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);

    logic at_fall;
    logic at_addr;
    logic at_data;
    logic at_sample;

    extbus_phi2_gen #(
        .HALF     (HALF),
        .ADDR_DLY (ADDR_DLY),
        .DATA_DLY (DATA_DLY)
    ) u_phi2_gen (
        .clk       (clk),
        .rst       (rst),
        .phi2      (extbus_phi2),
        .at_fall   (at_fall),
        .at_addr   (at_addr),
        .at_data   (at_data),
        .at_sample (at_sample)
    );

    logic               cmd_write_q;
    logic [ADDR_W-1:0]  cmd_addr_q;
    logic [7:0]         cmd_data_q;
    logic [COUNT_W-1:0] beats;
    // Set only when a beat actually started at the address edge; a command
    // accepted mid-period must not drive data or consume a beat until the next one.
    logic               beat_act;

    assign cmd_ready = !busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_data_q   <= '0;
            beats        <= '0;
            busy         <= 1'b0;
            beat_act     <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            extbus_a     <= IDLE_A;
            extbus_rw_n  <= 1'b1;
            extbus_d_out <= '0;
            extbus_d_oe  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;

            if (cmd_valid && cmd_ready) begin
                cmd_write_q <= cmd_write;
                cmd_addr_q  <= cmd_addr;
                cmd_data_q  <= cmd_data;
                beats       <= (cmd_count == '0) ? COUNT_W'(1) : cmd_count;
                busy        <= 1'b1;
            end

            if (at_addr) begin
                beat_act    <= busy;
                extbus_d_oe <= 1'b0;
                if (busy) begin
                    extbus_a    <= cmd_addr_q;
                    extbus_rw_n <= !cmd_write_q;
                end else begin
                    extbus_a    <= IDLE_A;
                    extbus_rw_n <= 1'b1;
                end
            end

            if (at_data && beat_act && !extbus_rw_n) begin
                extbus_d_out <= cmd_data_q;
                extbus_d_oe  <= 1'b1;
            end

            if (at_sample && beat_act && extbus_rw_n) begin
                rsp_valid <= 1'b1;
                rsp_data  <= extbus_d_in;
            end

            if (at_fall && beat_act) begin
                if (beats <= COUNT_W'(1)) begin
                    beats <= '0;
                    busy  <= 1'b0;
                end else begin
                    beats <= beats - COUNT_W'(1);
                end
            end
        end
    end

    assign extbus_cs_n = ((extbus_a & BASE_MASK) != BASE_ADDR);
    assign extbus_rd_n = !extbus_rw_n || !extbus_phi2;
    assign extbus_wr_n = extbus_rw_n || !extbus_phi2;

endmodule

// File: tb/tb_extbus_master.sv
// Directed bench for extbus_master (HALF=3, ADDR_DLY=1, DATA_DLY=1, decode 0x9F2x).
module tb_extbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_data;
    logic [7:0]  cmd_count;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        extbus_phi2;
    logic [15:0] extbus_a;
    logic        extbus_rw_n;
    logic        extbus_cs_n;
    logic        extbus_rd_n;
    logic        extbus_wr_n;
    logic [7:0]  extbus_d_out;
    logic        extbus_d_oe;
    logic [7:0]  extbus_d_in;

    extbus_master dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_count    (cmd_count),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .extbus_phi2  (extbus_phi2),
        .extbus_a     (extbus_a),
        .extbus_rw_n  (extbus_rw_n),
        .extbus_cs_n  (extbus_cs_n),
        .extbus_rd_n  (extbus_rd_n),
        .extbus_wr_n  (extbus_wr_n),
        .extbus_d_out (extbus_d_out),
        .extbus_d_oe  (extbus_d_oe),
        .extbus_d_in  (extbus_d_in)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Bus-side monitor and read-data model, sampled on the falling clk edge.
    int         cyc     = 0;
    int         wr_low  = 0;
    int         cs_low  = 0;
    int         oe_hi   = 0;
    int         rd_cnt  = 0;
    int         rsp_cnt = 0;
    logic [7:0] rsp_dat_q[$];
    int         rsp_cyc_q[$];
    logic       prev_rd_n = 1'b1;

    always @(negedge clk) begin
        cyc++;
        if (!extbus_wr_n) wr_low++;
        if (!extbus_cs_n) cs_low++;
        if (extbus_d_oe)  oe_hi++;
        if (rsp_valid) begin
            rsp_cnt++;
            rsp_dat_q.push_back(rsp_data);
            rsp_cyc_q.push_back(cyc);
        end
        if (!prev_rd_n && extbus_rd_n && !extbus_cs_n) rd_cnt++;
        prev_rd_n = extbus_rd_n;
    end

    assign extbus_d_in = 8'hA1 + rd_cnt[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command and returns once it has been accepted (cycles waited reported).
    task automatic send(input logic wr, input logic [15:0] addr, input logic [7:0] dat,
                        input logic [7:0] cnt, output int waited);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_data  = dat;
        cmd_count = cnt;
        waited    = 0;
        while (!cmd_ready && waited < 100) begin
            step(1);
            waited++;
        end
        chk("accept_ready", {31'd0, cmd_ready}, 32'd1);
        step(1);
        cmd_valid = 1'b0;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_phi2"},      {31'd0, extbus_phi2}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_a"},         {16'd0, extbus_a},  32'd0);
        chk({tag, "_rw_n"},      {31'd0, extbus_rw_n}, 32'd1);
        chk({tag, "_d_oe"},      {31'd0, extbus_d_oe}, 32'd0);
        chk({tag, "_rd_n"},      {31'd0, extbus_rd_n}, 32'd1);
        chk({tag, "_wr_n"},      {31'd0, extbus_wr_n}, 32'd1);
        chk({tag, "_cs_n"},      {31'd0, extbus_cs_n}, 32'd1);
    endtask

    initial begin
        int w;
        int wr0, cs0, oe0, r0, t_addr;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_data  = '0;
        cmd_count = '0;

        // 1. reset
        step(4);
        chk_idle_reset("rst");
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'h0);
        chk("rst_d_out", {24'd0, extbus_d_out}, 32'h0);
        rst = 1'b0;

        // 2. single write 0x9F25 <- 0x01, accepted on the address edge -> starts one period later
        send(1'b1, 16'h9F25, 8'h01, 8'd1, w);
        chk("w1_deferred_a", {16'd0, extbus_a}, 32'h0);
        chk("w1_busy", {31'd0, busy}, 32'd1);
        step(6);
        wr0 = wr_low; cs0 = cs_low;
        chk("w1_a", {16'd0, extbus_a}, 32'h9F25);
        chk("w1_cs_n", {31'd0, extbus_cs_n}, 32'd0);
        chk("w1_rw_n", {31'd0, extbus_rw_n}, 32'd0);
        chk("w1_oe_p1", {31'd0, extbus_d_oe}, 32'd0);
        step(2);
        chk("w1_phi2_p3", {31'd0, extbus_phi2}, 32'd1);
        chk("w1_wr_n_p3", {31'd0, extbus_wr_n}, 32'd0);
        chk("w1_oe_p3", {31'd0, extbus_d_oe}, 32'd0);
        step(1);
        chk("w1_oe_p4", {31'd0, extbus_d_oe}, 32'd1);
        chk("w1_d_out", {24'd0, extbus_d_out}, 32'h01);
        step(2);
        chk("w1_phi2_p0", {31'd0, extbus_phi2}, 32'd0);
        chk("w1_wr_n_p0", {31'd0, extbus_wr_n}, 32'd1);
        chk("w1_oe_hold", {31'd0, extbus_d_oe}, 32'd1);
        chk("w1_ready_p0", {31'd0, cmd_ready}, 32'd1);
        step(1);
        chk("w1_idle_a", {16'd0, extbus_a}, 32'h0);
        chk("w1_idle_oe", {31'd0, extbus_d_oe}, 32'd0);
        chk("w1_wr_cycles", wr_low - wr0, 32'd3);
        chk("w1_cs_cycles", cs_low - cs0, 32'd6);

        // 3. repeat write 0x9F24 <- 0xA5 x4, no idle gap, no rsp
        r0 = rsp_cnt;
        send(1'b1, 16'h9F24, 8'hA5, 8'd4, w);
        wr0 = wr_low; cs0 = cs_low;
        step(5);
        for (int b = 0; b < 4; b++) begin
            chk("rw_a", {16'd0, extbus_a}, 32'h9F24);
            step(3);
            chk("rw_d_out", {24'd0, extbus_d_out}, 32'hA5);
            chk("rw_oe", {31'd0, extbus_d_oe}, 32'd1);
            step(2);
            chk("rw_busy_p0", {31'd0, busy}, (b < 3) ? 32'd1 : 32'd0);
            step(1);
        end
        chk("rw_idle_a", {16'd0, extbus_a}, 32'h0);
        chk("rw_wr_cycles", wr_low - wr0, 32'd12);
        chk("rw_cs_cycles", cs_low - cs0, 32'd24);
        chk("rw_no_rsp", rsp_cnt - r0, 32'd0);

        // 4. repeat read 0x9F24 x4, model returns A1..A4
        send(1'b0, 16'h9F24, 8'h00, 8'd4, w);
        r0 = rsp_cnt; oe0 = oe_hi;
        step(5);
        t_addr = cyc + 1;
        chk("rr_a", {16'd0, extbus_a}, 32'h9F24);
        chk("rr_rw_n", {31'd0, extbus_rw_n}, 32'd1);
        step(24);
        chk("rr_busy_end", {31'd0, busy}, 32'd0);
        chk("rr_rsp_count", rsp_cnt - r0, 32'd4);
        chk("rr_no_oe", oe_hi - oe0, 32'd0);
        if (rsp_cnt - r0 == 4) begin
            chk("rr_latency", rsp_cyc_q[r0] - t_addr, 32'd5);
            for (int k = 0; k < 4; k++) begin
                chk("rr_data", {24'd0, rsp_dat_q[r0 + k]}, 32'hA1 + k);
                if (k > 0) chk("rr_spacing", rsp_cyc_q[r0 + k] - rsp_cyc_q[r0 + k - 1], 32'd6);
            end
        end

        // 5. non-decoded write to 0x1000, count 0 treated as one beat
        send(1'b1, 16'h1000, 8'h5A, 8'd0, w);
        wr0 = wr_low; cs0 = cs_low;
        step(5);
        chk("nd_a", {16'd0, extbus_a}, 32'h1000);
        chk("nd_cs_n", {31'd0, extbus_cs_n}, 32'd1);
        step(3);
        chk("nd_d_out", {24'd0, extbus_d_out}, 32'h5A);
        step(3);
        chk("nd_single_beat_a", {16'd0, extbus_a}, 32'h0);
        chk("nd_busy", {31'd0, busy}, 32'd0);
        chk("nd_wr_cycles", wr_low - wr0, 32'd3);
        chk("nd_cs_cycles", cs_low - cs0, 32'd0);

        // 6. reset during beat 2 of a count=8 read
        send(1'b0, 16'h9F24, 8'h00, 8'd8, w);
        r0 = rsp_cnt;
        step(5 + 6 + 2);
        chk("mr_rsp_before", rsp_cnt - r0, 32'd1);
        chk("mr_rd_n_mid", {31'd0, extbus_rd_n}, 32'd0);
        rst = 1'b1;
        step(1);
        chk_idle_reset("mr");
        rst = 1'b0;
        send(1'b1, 16'h9F21, 8'h3C, 8'd1, w);
        chk("mr_accept_wait", w, 32'd0);
        step(6);
        chk("mr_new_a", {16'd0, extbus_a}, 32'h9F21);
        chk("mr_new_rw_n", {31'd0, extbus_rw_n}, 32'd0);
        step(3);
        chk("mr_new_d_out", {24'd0, extbus_d_out}, 32'h3C);
        step(3);
        chk("mr_new_busy", {31'd0, busy}, 32'd0);
        chk("mr_rsp_after", rsp_cnt - r0, 32'd1);
        if (rsp_cnt - r0 >= 1) chk("mr_rsp_data", {24'd0, rsp_dat_q[r0]}, 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
